// File: rtl/mv_mult_scheduler_pkg.sv
// Shared types and packing constants for the matrix-vector scheduler.
// Operand/result layouts match the engine port packing byte for byte.
package mv_pkg;
    localparam int ELEM_W = 8;
    localparam int RES_W  = 16;
    localparam int A_W    = 9 * ELEM_W;
    localparam int B_W    = 3 * ELEM_W;
    localparam int C_W    = 3 * RES_W;

    localparam int A11_OFF = 0 * ELEM_W;
    localparam int A12_OFF = 1 * ELEM_W;
    localparam int A13_OFF = 2 * ELEM_W;
    localparam int A21_OFF = 3 * ELEM_W;
    localparam int A22_OFF = 4 * ELEM_W;
    localparam int A23_OFF = 5 * ELEM_W;
    localparam int A31_OFF = 6 * ELEM_W;
    localparam int A32_OFF = 7 * ELEM_W;
    localparam int A33_OFF = 8 * ELEM_W;
    localparam int B1_OFF  = 0 * ELEM_W;
    localparam int B2_OFF  = 1 * ELEM_W;
    localparam int B3_OFF  = 2 * ELEM_W;
    localparam int C1_OFF  = 0 * RES_W;
    localparam int C2_OFF  = 1 * RES_W;
    localparam int C3_OFF  = 2 * RES_W;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        ARM   = 3'd2,
        WAIT  = 3'd3,
        RESP  = 3'd4
    } state_e;
endpackage

// File: rtl/mv_mult_scheduler_if.sv
// Client request/response and engine start/done signals of the scheduler.
// master = clients plus engine side, slave = the scheduler itself.
interface mv_mult_scheduler_if
    import mv_pkg::*;
#(
    parameter int N_REQ = 4
);
    localparam int ID_W = $clog2(N_REQ);

    logic [N_REQ-1:0]     req;
    logic [N_REQ*A_W-1:0] req_a;
    logic [N_REQ*B_W-1:0] req_b;
    logic [N_REQ-1:0]     gnt;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [ID_W-1:0]      rsp_id;
    logic [C_W-1:0]       rsp_c;
    logic                 rsp_err;
    logic                 busy;
    logic                 eng_start;
    logic [A_W-1:0]       eng_a;
    logic [B_W-1:0]       eng_b;
    logic                 eng_done;
    logic [C_W-1:0]       eng_c;

    modport master (
        output req, req_a, req_b, rsp_ready, eng_done, eng_c,
        input  gnt, rsp_valid, rsp_id, rsp_c, rsp_err, busy, eng_start, eng_a, eng_b
    );

    modport slave (
        input  req, req_a, req_b, rsp_ready, eng_done, eng_c,
        output gnt, rsp_valid, rsp_id, rsp_c, rsp_err, busy, eng_start, eng_a, eng_b
    );
endinterface

// File: rtl/mv_mult_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first set request at or above the pointer, with wrap.
// The pointer register is owned by the caller.
module rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int ID_W  = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [ID_W-1:0]  i_ptr,
    input  logic             i_en,
    output logic [N_REQ-1:0] o_gnt,
    output logic [ID_W-1:0]  o_idx,
    output logic             o_vld
);
    logic w_found;

    always_comb begin
        w_found = 1'b0;
        o_idx   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (!w_found && i_req[(int'(i_ptr) + k) % N_REQ]) begin
                w_found = 1'b1;
                o_idx   = ID_W'((int'(i_ptr) + k) % N_REQ);
            end
        end
        o_vld = w_found && i_en;
        o_gnt = '0;
        if (o_vld) o_gnt[o_idx] = 1'b1;
    end
endmodule

// File: rtl/mv_mult_scheduler.sv
// Shares one 3x3 matrix-vector engine among N_REQ clients: round-robin grant,
// operand capture, engine start/done sequencing with timeout, valid/ready response.
module mv_mult_scheduler
    import mv_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic                clk,
    input  logic                rst,
    mv_mult_scheduler_if.slave  bus
);
    localparam int ID_W  = $clog2(N_REQ);
    localparam int CNT_W = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_e           r_state;
    state_e           w_next;
    logic [ID_W-1:0]  r_ptr;
    logic [ID_W-1:0]  r_id;
    logic [ID_W-1:0]  w_win;
    logic [N_REQ-1:0] w_gnt;
    logic             w_any;
    logic [CNT_W-1:0] r_cnt;
    logic [A_W-1:0]   r_a;
    logic [B_W-1:0]   r_b;
    logic [C_W-1:0]   r_c;
    logic             r_err;

    // Grants are suppressed under reset so nothing is captured on a reset edge.
    rr_arbiter #(.N_REQ(N_REQ), .ID_W(ID_W)) u_arb (
        .i_req (bus.req),
        .i_ptr (r_ptr),
        .i_en  ((r_state == IDLE) && !rst),
        .o_gnt (w_gnt),
        .o_idx (w_win),
        .o_vld (w_any)
    );

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next        = r_state;
        bus.eng_start = 1'b0;
        bus.rsp_valid = 1'b0;
        bus.busy      = 1'b1;
        case (r_state)
            IDLE: begin
                bus.busy = 1'b0;
                if (w_any) w_next = ISSUE;
            end
            ISSUE: begin
                bus.eng_start = 1'b1;
                w_next        = ARM;
            end
            // done is still high from the previous operation here; skip it
            ARM:  w_next = WAIT;
            WAIT: if (bus.eng_done || (r_cnt == CNT_LAST)) w_next = RESP;
            RESP: begin
                bus.rsp_valid = 1'b1;
                if (bus.rsp_ready) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= '0;
            r_id  <= '0;
            r_cnt <= '0;
            r_a   <= '0;
            r_b   <= '0;
            r_c   <= '0;
            r_err <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (w_any) begin
                    r_a   <= bus.req_a[int'(w_win)*A_W +: A_W];
                    r_b   <= bus.req_b[int'(w_win)*B_W +: B_W];
                    r_id  <= w_win;
                    r_ptr <= (w_win == ID_W'(N_REQ - 1)) ? '0 : w_win + 1'b1;
                end
                ARM: r_cnt <= '0;
                WAIT: begin
                    // done takes priority over a coincident timeout
                    if (bus.eng_done) begin
                        r_c   <= bus.eng_c;
                        r_err <= 1'b0;
                    end else if (r_cnt == CNT_LAST) begin
                        r_c   <= '0;
                        r_err <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.gnt     = w_gnt;
    assign bus.rsp_id  = r_id;
    assign bus.rsp_c   = r_c;
    assign bus.rsp_err = r_err;
    assign bus.eng_a   = r_a;
    assign bus.eng_b   = r_b;
endmodule

// File: tb/tb_mv_mult_scheduler.sv
// Bench for mv_mult_scheduler: directed scenarios plus random traffic against a
// transaction-level model (rr winner, fixed latencies, pass-through results).
module tb_mv_mult_scheduler;
    import mv_pkg::*;

    localparam int N  = 4;
    localparam int TO = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mv_mult_scheduler_if #(.N_REQ(N)) bus();

    mv_mult_scheduler #(.N_REQ(N), .TIMEOUT(TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    bit hang   = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [47:0] mvmul(input logic [71:0] a, input logic [23:0] b);
        logic [47:0] c;
        int s;
        c = '0;
        for (int r = 0; r < 3; r++) begin
            s = 0;
            for (int k = 0; k < 3; k++)
                s += int'(a[(3*r+k)*8 +: 8]) * int'(b[k*8 +: 8]);
            c[r*16 +: 16] = s[15:0];
        end
        return c;
    endfunction

    // Engine stand-in: done rises 4 cycles after start and stays high until the next start.
    int e_cnt;
    always @(posedge clk) begin
        if (rst) begin
            e_cnt        <= 0;
            bus.eng_done <= 1'b0;
            bus.eng_c    <= '0;
        end else if (bus.eng_start) begin
            e_cnt        <= 4;
            bus.eng_done <= 1'b0;
        end else if (e_cnt != 0) begin
            e_cnt <= e_cnt - 1;
            if (e_cnt == 1 && !hang) begin
                bus.eng_done <= 1'b1;
                bus.eng_c    <= mvmul(bus.eng_a, bus.eng_b);
            end
        end
    end

    // Transaction model: one open job at a time, response due a fixed number of cycles after grant.
    bit          m_open = 1'b0;
    int          m_age, m_ptr, m_id, m_lat, m_w;
    int          served = 0;
    logic [N-1:0] m_eg;
    logic [71:0] m_a;
    logic [23:0] m_b;
    logic [47:0] m_c;
    logic        m_err;

    always @(negedge clk) begin
        if (rst) begin
            m_open = 1'b0;
            m_ptr  = 0;
        end else if (!m_open) begin
            m_w = -1;
            for (int k = 0; k < N; k++)
                if (m_w < 0 && bus.req[(m_ptr + k) % N]) m_w = (m_ptr + k) % N;
            m_eg = '0;
            if (m_w >= 0) m_eg[m_w] = 1'b1;
            chk("m_gnt", bus.gnt, m_eg);
            chk("m_idle_busy", bus.busy, 0);
            chk("m_idle_valid", bus.rsp_valid, 0);
            if (m_w >= 0) begin
                m_open = 1'b1;
                m_age  = 0;
                m_id   = m_w;
                m_a    = bus.req_a[m_w*72 +: 72];
                m_b    = bus.req_b[m_w*24 +: 24];
                m_err  = hang;
                m_c    = hang ? 48'd0 : mvmul(m_a, m_b);
                m_lat  = hang ? 3 + TO : 7;
                m_ptr  = (m_w + 1) % N;
            end
        end else begin
            m_age++;
            chk("m_busy_gnt", bus.gnt, 0);
            chk("m_busy", bus.busy, 1);
            chk("m_start", bus.eng_start, 64'(m_age == 1));
            chk("m_eng_a", bus.eng_a, m_a);
            chk("m_eng_b", bus.eng_b, m_b);
            chk("m_valid", bus.rsp_valid, 64'(m_age >= m_lat));
            if (m_age >= m_lat) begin
                chk("m_id", bus.rsp_id, m_id);
                chk("m_c", bus.rsp_c, m_c);
                chk("m_err", bus.rsp_err, m_err);
                if (bus.rsp_ready) begin
                    m_open = 1'b0;
                    served++;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_gnt(output logic [N-1:0] g, output int t);
        g = '0;
        t = -1;
        for (int i = 0; i < 40 && g == 0; i++) begin
            @(negedge clk);
            if (bus.gnt != 0) begin
                g = bus.gnt;
                t = cyc;
            end
        end
        if (g == 0) begin
            checks++;
            errors++;
            $display("FAIL wait_gnt: no grant within 40 cycles (cycle %0d)", cyc);
        end
        step();
    endtask

    task automatic wait_valid(output int t);
        t = -1;
        for (int i = 0; i < 60 && t < 0; i++) begin
            @(negedge clk);
            if (bus.rsp_valid) t = cyc;
        end
        if (t < 0) begin
            checks++;
            errors++;
            $display("FAIL wait_valid: no response within 60 cycles (cycle %0d)", cyc);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic [N-1:0] g, lg;
    int           tg, tv;
    logic [71:0]  a;
    logic [95:0]  rnd;
    logic [47:0]  c0;
    int           ord [5] = '{0, 1, 2, 3, 0};

    initial begin
        bus.req       = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        @(negedge clk);
        chk("rst_busy", bus.busy, 0);
        chk("rst_valid", bus.rsp_valid, 0);
        chk("rst_gnt", bus.gnt, 0);
        chk("rst_start", bus.eng_start, 0);
        chk("rst_c", bus.rsp_c, 0);
        chk("rst_id", bus.rsp_id, 0);
        chk("rst_err", bus.rsp_err, 0);
        chk("rst_eng_a", bus.eng_a, 0);
        chk("rst_eng_b", bus.eng_b, 0);
        step();

        // identity matrix, b=(1,2,3), requester 2 alone
        a = '0;
        a[7:0] = 8'd1; a[39:32] = 8'd1; a[71:64] = 8'd1;
        bus.req_a[2*72 +: 72] = a;
        bus.req_b[2*24 +: 24] = {8'd3, 8'd2, 8'd1};
        bus.req = 4'b0100;
        wait_gnt(g, tg);
        chk("id_gnt", g, 4'b0100);
        bus.req = '0;
        wait_valid(tv);
        chk("id_latency", 64'(tv - tg), 7);
        chk("id_c", bus.rsp_c, 48'h0003_0002_0001);
        chk("id_id", bus.rsp_id, 2);
        chk("id_err", bus.rsp_err, 0);
        step();

        // all-255 operands, requester 0 reached by wrap from pointer 3
        bus.req_a[0 +: 72] = {72{1'b1}};
        bus.req_b[0 +: 24] = {24{1'b1}};
        bus.req = 4'b0001;
        wait_gnt(g, tg);
        chk("max_gnt", g, 4'b0001);
        bus.req = '0;
        wait_valid(tv);
        chk("max_c", bus.rsp_c, 48'hFA03_FA03_FA03);
        step();

        // round robin from pointer 0 with every requester always asking
        rst = 1'b1;
        step();
        rst = 1'b0;
        bus.req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            wait_gnt(g, tg);
            chk("rr_gnt", g, 64'd1 << ord[k]);
            if (k == 4) bus.req = '0;
            wait_valid(tv);
            chk("rr_id", bus.rsp_id, ord[k]);
            step();
        end

        // response stall with other requests pending
        bus.rsp_ready = 1'b0;
        bus.req = 4'b0010;
        wait_gnt(g, tg);
        chk("stall_gnt", g, 4'b0010);
        bus.req = 4'b1101;
        wait_valid(tv);
        c0 = bus.rsp_c;
        for (int k = 0; k < 5; k++) begin
            step();
            @(negedge clk);
            chk("stall_valid", bus.rsp_valid, 1);
            chk("stall_c", bus.rsp_c, c0);
            chk("stall_gnt0", bus.gnt, 0);
        end
        step();
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        chk("stall_hold", bus.rsp_valid, 1);
        step();
        @(negedge clk);
        chk("stall_drop", bus.rsp_valid, 0);
        chk("stall_next_gnt", bus.gnt, 4'b0100);
        step();
        bus.req = '0;
        wait_valid(tv);
        chk("stall_next_id", bus.rsp_id, 2);
        step();

        // engine that never finishes
        hang = 1'b1;
        bus.req = 4'b1000;
        wait_gnt(g, tg);
        chk("to_gnt", g, 4'b1000);
        bus.req = '0;
        wait_valid(tv);
        chk("to_latency", 64'(tv - tg), 3 + TO);
        chk("to_err", bus.rsp_err, 1);
        chk("to_c", bus.rsp_c, 0);
        step();
        hang = 1'b0;
        bus.req_a[0 +: 72] = {9{8'd1}};
        bus.req_b[0 +: 24] = {3{8'd1}};
        bus.req = 4'b0001;
        wait_gnt(g, tg);
        chk("after_to_gnt", g, 4'b0001);
        bus.req = '0;
        wait_valid(tv);
        chk("after_to_latency", 64'(tv - tg), 7);
        chk("after_to_err", bus.rsp_err, 0);
        chk("after_to_c", bus.rsp_c, 48'h0003_0003_0003);
        step();

        // reset in WAIT, then pointer restarts at 0
        bus.req = 4'b0100;
        wait_gnt(g, tg);
        bus.req = '0;
        step();
        step();
        rst = 1'b1;
        bus.req = 4'b1010;
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("rstw_busy", bus.busy, 0);
        chk("rstw_valid", bus.rsp_valid, 0);
        chk("rstw_gnt", bus.gnt, 4'b0010);
        step();
        bus.req = 4'b1000;
        wait_valid(tv);
        chk("rstw_id1", bus.rsp_id, 1);
        step();
        wait_gnt(g, tg);
        chk("rstw_gnt3", g, 4'b1000);
        bus.req = '0;
        wait_valid(tv);
        chk("rstw_id3", bus.rsp_id, 3);
        step();

        // random traffic: checked by the model process
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            lg = bus.gnt;
            step();
            for (int i = 0; i < N; i++) begin
                if (lg[i] || (!bus.req[i] && $urandom_range(3) == 0)) begin
                    bus.req[i] = lg[i] ? ($urandom_range(1) == 1) : 1'b1;
                    rnd = {$urandom, $urandom, $urandom};
                    bus.req_a[i*72 +: 72] = rnd[71:0];
                    bus.req_b[i*24 +: 24] = rnd[95:72];
                end else if (bus.req[i] && $urandom_range(15) == 0) begin
                    bus.req[i] = 1'b0;
                end
            end
            bus.rsp_ready = ($urandom_range(2) != 0);
            if (!bus.busy) hang = ($urandom_range(7) == 0);
        end
        bus.req = '0;
        bus.rsp_ready = 1'b1;
        repeat (40) step();
        hang = 1'b0;
        chk("served_enough", 64'(served > 60), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mv_mult_scheduler.md
Name: mv_mult_scheduler

Overview:
Shares one 3x3-by-3 matrix-vector multiply engine between N_REQ requesters. Uses round-robin arbitration and captures the winner's operands into holding registers. Sequences the engine's start/done protocol, guards the wait with a timeout, and returns the result with the requester ID over a valid/ready response channel. Sits between the client ports and a single matrix_mult instance.

Parameters:
N_REQ, 4, number of requesters (2..8)
TIMEOUT, 64, max WAIT cycles before an error response (>=8)
ID_W, clog2(N_REQ), localparam, width of the requester ID

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
req  in  N_REQ  per-requester request; held with operands until gnt
req_a  in  N_REQ*72  per requester, 9 bytes; a11 at [7:0], a12 at [15:8] … a33 at [71:64]
req_b  in  N_REQ*24  per requester; b1 at [7:0], b2 at [15:8], b3 at [23:16]
gnt  out  N_REQ  one-hot; high in the cycle operands are captured
rsp_valid  out  1  response valid
rsp_ready  in  1  response accepted when high with rsp_valid
rsp_id  out  ID_W  index of the served requester
rsp_c  out  48  c1 at [15:0], c2 at [31:16], c3 at [47:32]
rsp_err  out  1  timeout flag; rsp_c=0 when set
busy  out  1  high in any state other than IDLE
eng_start  out  1  engine start, single-cycle pulse
eng_a  out  72  registered operands, stable from capture until RESP ends
eng_b  out  24  registered operands, stable from capture until RESP ends
eng_done  in  1  engine done; a level that stays high until the next start
eng_c  in  48  engine result, same packing as rsp_c

Behaviour:
- Reset (synchronous, priority over everything else):
  - state=IDLE, rr pointer=0.
  - gnt=0, eng_start=0, rsp_valid=0, rsp_err=0, busy=0.
  - rsp_c, rsp_id, eng_a, eng_b, timeout counter all =0.
- Reset mid-operation: returns to IDLE next cycle and drops any in-flight response. The engine shares rst, so both restart clean.
- FSM states: IDLE, ISSUE, ARM, WAIT, RESP.
- IDLE:
  - With any req bit set: grant the first set bit at or after the pointer, scanning upward with wrap.
  - gnt is combinational from state and req, asserted only in IDLE.
  - On that edge: latch req_a/req_b of the winner into eng_a/eng_b and latch the winner's ID.
  - Pointer becomes (winner+1) mod N_REQ. Next state ISSUE.
  - With req=0: stay in IDLE; pointer unchanged.
- ISSUE: eng_start=1 for exactly this cycle; next state ARM.
- ARM: ignore eng_done, which is stale high from the previous operation; next state WAIT; counter cleared.
- WAIT:
  - If eng_done=1: capture eng_c into rsp_c, set rsp_err=0, go to RESP.
  - Else if counter==TIMEOUT-1: set rsp_c=0, rsp_err=1, go to RESP.
  - Else increment the counter.
  - If done and timeout coincide, done wins.
- RESP:
  - rsp_valid=1; rsp_c, rsp_id and rsp_err held stable.
  - When rsp_ready=1: go to IDLE, rsp_valid drops next cycle.
  - No new grant while in RESP, so there is no back-to-back overlap. The earliest next gnt is the cycle after the handshake.
- Latency: with the engine at its 4-cycle latency, gnt at cycle t gives rsp_valid at t+7. Throughput is one operation per 8 cycles when rsp_ready=1.
- Arithmetic: none in the scheduler. Results are passed through as 16-bit values, already wrapped mod 2^16 by the engine.
- Request held but never granted: stays pending. Round-robin bounds the wait to N_REQ-1 services.
- A req that drops before gnt is simply not served.

Decomposition:
- Shared package mv_pkg holds:
  - state encoding enum (IDLE=0 … RESP=4);
  - operand and result packing constants A_W=72, B_W=24, C_W=48, ELEM_W=8, RES_W=16;
  - the element offset localparams.
- One sub-module: rr_arbiter (N_REQ param).
  - Inputs: req, pointer, enable.
  - Outputs: one-hot gnt, winner index.
  - Purely combinational; the pointer register lives in the scheduler.

Test Plan:
- Identity matrix with b=(1,2,3) from requester 2 alone -> gnt=0b0100; rsp_c={16'd3,16'd2,16'd1}, rsp_id=2, rsp_err=0, rsp_valid exactly 7 cycles after gnt.
- All a=255, b=255 -> each element 195075 mod 65536 = 64003 (0xFA03); rsp_c=48'hFA03_FA03_FA03.
- req=0b1111 held continuously (each requester re-raises after its gnt) -> grant order 0,1,2,3,0; each rsp_id matches.
- rsp_ready low for 5 cycles in RESP -> rsp_valid and rsp_c stay stable, no gnt during stall; a single accept on ready.
- Engine model that never raises done, TIMEOUT=16 -> rsp_err=1 and rsp_c=0 after 16 WAIT cycles; the next request is then served normally.
- rst asserted during WAIT -> next cycle busy=0, rsp_valid=0, pointer=0; a following req on 1 and 3 grants requester 1 first.
